// File: rtl/request_former_mc_if.sv
// request_former_mc_if
//   Groups the per-channel receive-done inputs and the request/status
//   outputs of request_former_mc into one bundle.
//   Signals (CH = channel count, CNT_W = total counter width):
//     en        [CH]    per-channel enable
//     RXdone    [CH]    receiver-done lines, asynchronous to clk
//     err_clr   [CH]    per-channel sticky error clear strobe
//     req       [CH]    request pulses
//     busy      [CH]    channel not idle
//     err       [CH]    sticky timeout flags
//     req_total [CNT_W] running count of pulses started
//   Modports: master drives the inputs, slave is the request former.
interface request_former_mc_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  logic [CH-1:0]    en;
  logic [CH-1:0]    RXdone;
  logic [CH-1:0]    err_clr;
  logic [CH-1:0]    req;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    err;
  logic [CNT_W-1:0] req_total;

  modport master (output en, RXdone, err_clr, input req, busy, err, req_total);
  modport slave  (input en, RXdone, err_clr, output req, busy, err, req_total);
endinterface

// File: rtl/request_former_mc.sv
// request_former_mc
//   Multi-channel request former for the receive path. Each channel
//   synchronises its RXdone line, fires one req pulse of PULSE_W cycles
//   when it sees the line low (and is enabled), then waits for the line to
//   return high before it can fire again. req_total counts every pulse
//   started across all channels, modulo 2^CNT_W.
//   Optional build macro REQFORM_TIMEOUT_EN: a channel stuck low in WAITHI
//   for TO_CYC cycles raises a sticky err flag, returns to IDLE and stays
//   disarmed until its line has been seen high. Without the macro err is 0
//   and WAITHI waits indefinitely.
//   Ports:
//     clk  system clock, rising edge
//     RST  asynchronous active-high reset
//     bus  request_former_mc_if.slave (en, RXdone, err_clr in;
//          req, busy, err, req_total out)

// One channel: 2-flop synchroniser plus IDLE/REQ/WAITHI state machine.
module request_former_ch #(
  parameter int PULSE_W = 5,
  parameter int TO_CYC  = 1024
) (
  input  logic clk,
  input  logic RST,
  input  logic i_en,
  input  logic i_rxdone,
  input  logic i_err_clr,
  output logic o_req,
  output logic o_busy,
  output logic o_err,
  output logic o_start
);
  localparam int PW = $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAITHI} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          w_rxs;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic          r_req, w_req_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_start;
  logic          w_arm;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_rxdone};
  end
  assign w_rxs = r_sync[1];

`ifdef REQFORM_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC);

  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_blk, w_blk_nxt;
  logic          r_err, w_err_nxt;

  // After a timeout the line is still low; r_blk keeps the channel from
  // re-firing on that same low period.
  assign w_arm = ~r_blk;
`else
  logic w_unused;
  localparam int unused_to_cyc = TO_CYC;
  assign w_unused = i_err_clr;
  assign w_arm    = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_req_nxt   = r_req;
    w_busy_nxt  = r_busy;
    w_start     = 1'b0;
`ifdef REQFORM_TIMEOUT_EN
    w_tcnt_nxt  = r_tcnt;
    w_blk_nxt   = r_blk & ~w_rxs;
    w_err_nxt   = r_err & ~i_err_clr;
`endif
    case (r_state)
      IDLE: begin
        if (i_en && !w_rxs && w_arm) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_pcnt_nxt  = PW'(1);
          w_start     = 1'b1;
        end
      end
      REQ: begin
        if (r_pcnt == PW'(PULSE_W)) begin
          w_state_nxt = WAITHI;
          w_req_nxt   = 1'b0;
`ifdef REQFORM_TIMEOUT_EN
          w_tcnt_nxt  = '0;
`endif
        end else begin
          w_pcnt_nxt = r_pcnt + PW'(1);
        end
      end
      WAITHI: begin
        // A rising line wins over a coincident timeout.
        if (w_rxs) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
`ifdef REQFORM_TIMEOUT_EN
        else if (r_tcnt == TW'(TO_CYC - 1)) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = 1'b1;  // set beats a same-cycle clear
          w_blk_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

`ifdef REQFORM_TIMEOUT_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_tcnt <= '0;
      r_blk  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_blk  <= w_blk_nxt;
      r_err  <= w_err_nxt;
    end
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_req   = r_req;
  assign o_busy  = r_busy;
  assign o_start = w_start;
endmodule

module request_former_mc #(
  parameter int CH      = 4,
  parameter int PULSE_W = 5,
  parameter int CNT_W   = 16,
  parameter int TO_CYC  = 1024
) (
  input logic               clk,
  input logic               RST,
  request_former_mc_if.slave bus
);
  logic [CH-1:0]    w_req, w_busy, w_err, w_start;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] r_total;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    request_former_ch #(
      .PULSE_W (PULSE_W),
      .TO_CYC  (TO_CYC)
    ) u_ch (
      .clk       (clk),
      .RST       (RST),
      .i_en      (bus.en[g]),
      .i_rxdone  (bus.RXdone[g]),
      .i_err_clr (bus.err_clr[g]),
      .o_req     (w_req[g]),
      .o_busy    (w_busy[g]),
      .o_err     (w_err[g]),
      .o_start   (w_start[g])
    );
  end

  // Number of channels starting a pulse this cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CH; i++) w_pop = w_pop + CNT_W'(w_start[i]);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_total <= '0;
    else     r_total <= r_total + w_pop;
  end

  assign bus.req       = w_req;
  assign bus.busy      = w_busy;
  assign bus.err       = w_err;
  assign bus.req_total = r_total;
endmodule

// File: tb/tb_request_former_mc.sv
// tb_request_former_mc
//   Directed bench for request_former_mc. The main instance (CH=4,
//   PULSE_W=5, TO_CYC=8) is tracked by a pulse scoreboard: every expected
//   pulse (channel, rise cycle, width) is queued when its stimulus is
//   driven and popped when the monitor sees the pulse end. A second
//   16-channel instance is used to walk req_total up to its wrap point
//   in a reasonable number of cycles.
module tb_request_former_mc;
  localparam int CH = 4;
  localparam int PW = 5;

  typedef struct {
    int ch;
    int rise;   // -1: rise cycle not checked
    int width;
  } exp_t;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sbq[$];

  request_former_mc_if #(.CH(CH), .CNT_W(16)) bus ();
  request_former_mc_if #(.CH(16), .CNT_W(16)) bus2 ();

  request_former_mc #(.CH(CH), .PULSE_W(PW), .CNT_W(16), .TO_CYC(8)) dut (
    .clk (clk), .RST (RST), .bus (bus)
  );
  request_former_mc #(.CH(16), .PULSE_W(PW), .CNT_W(16), .TO_CYC(8)) dut2 (
    .clk (clk), .RST (RST), .bus (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int ch, input int rise);
    exp_t e;
    e.ch = ch; e.rise = rise; e.width = PW;
    sbq.push_back(e);
  endtask

  // Pulse monitor: measures each req pulse and retires it against the queue.
  logic [CH-1:0] prev;
  int            rise_at[CH];
  always @(negedge clk or posedge RST) begin
    if (RST) prev = '0;
    else begin
      for (int c = 0; c < CH; c++) begin
        if (bus.req[c] && !prev[c]) rise_at[c] = cyc;
        if (!bus.req[c] && prev[c]) begin
          if (sbq.size() == 0) chk("sb_unexpected_pulse", 32'(c), 32'hFF);
          else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_channel", 32'(c), 32'(e.ch));
            if (e.rise >= 0) chk("sb_rise_cycle", 32'(rise_at[c]), 32'(e.rise));
            chk("sb_width", 32'(cyc - rise_at[c]), 32'(e.width));
          end
        end
      end
      prev = bus.req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.en = '0; bus.RXdone = '1; bus.err_clr = '0;
    bus2.en = '1; bus2.RXdone = '1; bus2.err_clr = '0;

    // Reset state
    #1;
    chk("rst_req", 32'(bus.req), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_total", 32'(bus.req_total), 0);
    step(2); RST = 1'b0; step(2);

    // Single pulse: latency, width, busy until line high
    bus.en = 4'hF; step(1);
    n = cyc; bus.RXdone[0] = 1'b0; expect_pulse(0, n + 3);
    step(2);
    chk("lat_req_early", 32'(bus.req[0]), 0);
    step(1);
    chk("lat_req_rise", 32'(bus.req[0]), 1);
    chk("lat_busy", 32'(bus.busy[0]), 1);
    chk("lat_total", 32'(bus.req_total), 1);
    step(5);
    chk("pulse_end_busy", 32'(bus.busy[0]), 1);
    step(42);  // line low for 50 cycles: still a single pulse
    chk("hold_low_busy", 32'(bus.busy[0]), 1);
    chk("hold_low_total", 32'(bus.req_total), 1);
    n = cyc; bus.RXdone[0] = 1'b1;
    step(2);
    chk("rearm_busy_hold", 32'(bus.busy[0]), 1);
    step(1);
    chk("rearm_busy_clr", 32'(bus.busy[0]), 0);
    step(2);
    n = cyc; bus.RXdone[0] = 1'b0; expect_pulse(0, n + 3);
    step(3);
    chk("second_pulse_total", 32'(bus.req_total), 2);
    step(6); bus.RXdone[0] = 1'b1; step(4);
    chk("second_idle", 32'(bus.busy), 0);

    // All channels start together
    n = cyc; bus.RXdone = 4'h0;
    for (int c = 0; c < CH; c++) expect_pulse(c, n + 3);
    step(2);
    chk("all_total_pre", 32'(bus.req_total), 2);
    step(1);
    chk("all_total_step", 32'(bus.req_total), 6);
    chk("all_req", 32'(bus.req), 32'hF);
    step(6); bus.RXdone = 4'hF; step(4);
    chk("all_idle", 32'(bus.busy), 0);

    // Enable gates the start
    bus.en = 4'b1101; bus.RXdone[1] = 1'b0;
    step(20);
    chk("dis_busy", 32'(bus.busy[1]), 0);
    chk("dis_total", 32'(bus.req_total), 6);
    bus.en = 4'hF; expect_pulse(1, -1);
    step(2);
    chk("en_total", 32'(bus.req_total), 7);
    step(6); bus.RXdone[1] = 1'b1; step(4);
    chk("en_idle", 32'(bus.busy), 0);

`ifdef REQFORM_TIMEOUT_EN
    // Stuck line times out, stays disarmed, sticky error
    n = cyc; bus.RXdone[2] = 1'b0; expect_pulse(2, n + 3);
    step(15);
    chk("to_err_pre", 32'(bus.err[2]), 0);
    chk("to_busy_pre", 32'(bus.busy[2]), 1);
    step(1);
    chk("to_err_set", 32'(bus.err[2]), 1);
    chk("to_busy_clr", 32'(bus.busy[2]), 0);
    step(20);
    chk("to_no_retrig", 32'(bus.busy[2]), 0);
    chk("to_err_sticky", 32'(bus.err[2]), 1);
    bus.err_clr[2] = 1'b1; step(1); bus.err_clr[2] = 1'b0;
    chk("to_err_cleared", 32'(bus.err[2]), 0);
    bus.RXdone[2] = 1'b1; step(4);
    n = cyc; bus.RXdone[2] = 1'b0; expect_pulse(2, n + 3);
    step(15);
    chk("to2_err_pre", 32'(bus.err[2]), 0);
    bus.err_clr[2] = 1'b1; step(1); bus.err_clr[2] = 1'b0;
    chk("to_set_wins", 32'(bus.err[2]), 1);
    bus.err_clr[2] = 1'b1; step(1); bus.err_clr[2] = 1'b0;
    bus.RXdone[2] = 1'b1; step(4);
    chk("to_final_err", 32'(bus.err[2]), 0);
    chk("to_final_busy", 32'(bus.busy[2]), 0);
`else
    // Without timeout a stuck line just waits
    n = cyc; bus.RXdone[2] = 1'b0; expect_pulse(2, n + 3);
    step(30);
    chk("nto_busy", 32'(bus.busy[2]), 1);
    chk("nto_err", 32'(bus.err), 0);
    bus.RXdone[2] = 1'b1; step(4);
    chk("nto_idle", 32'(bus.busy[2]), 0);
`endif

    // req_total wrap on the 16-channel instance (high glitch in REQ ignored)
    bus2.RXdone = 16'h0000;
    step(2);
    chk("w16_total_pre", 32'(bus2.req_total), 0);
    step(1);
    chk("w16_total_step", 32'(bus2.req_total), 16);
    bus2.RXdone = 16'hFFFF; step(4);
    for (int k = 1; k < 4095; k++) begin
      bus2.RXdone = 16'h0000; step(3);
      bus2.RXdone = 16'hFFFF; step(4);
    end
    chk("w16_total_fff0", 32'(bus2.req_total), 32'hFFF0);
    bus2.RXdone = 16'hC000; step(3);
    bus2.RXdone = 16'hFFFF; step(4);
    chk("w16_total_fffe", 32'(bus2.req_total), 32'hFFFE);
    bus2.RXdone = 16'hFFFC;
    step(2);
    chk("w16_wrap_pre", 32'(bus2.req_total), 32'hFFFE);
    step(1);
    chk("w16_wrap", 32'(bus2.req_total), 0);
    bus2.RXdone = 16'hFFFF; step(8);

    // Asynchronous reset mid-pulse
    n = cyc; bus.RXdone[0] = 1'b0; expect_pulse(0, n + 3);
    step(5);
    chk("mid_pulse_req", 32'(bus.req[0]), 1);
    #2;
    RST = 1'b1; bus.RXdone = 4'hF; sbq.delete();
    #1;
    chk("rst_async_req", 32'(bus.req[0]), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    chk("rst_async_total", 32'(bus.req_total), 0);
    #1;
    RST = 1'b0;
    step(2);
    chk("post_rst_total", 32'(bus.req_total), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_total2", 32'(bus2.req_total), 0);
    n = cyc; bus.RXdone[0] = 1'b0; expect_pulse(0, n + 3);
    step(3);
    chk("post_rst_pulse_total", 32'(bus.req_total), 1);
    step(6); bus.RXdone[0] = 1'b1; step(4);
    chk("post_rst_idle", 32'(bus.busy), 0);

    chk("sb_all_retired", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
